// File: rtl/arb_pkg.sv
// Shared definitions for the eight-way round-robin arbiter: sizes, FSM states
// and the rotating-priority search used by rr_arbiter8.
package arb_pkg;

  localparam int NREQ  = 8;
  localparam int IDX_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Result of a round-robin search: whether any request was found, and which.
  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } sel_t;

  // Scan start, start+1, ... modulo NREQ and return the first index with req set.
  function automatic sel_t rr_search(input logic [NREQ-1:0]  req,
                                     input logic [IDX_W-1:0] start);
    sel_t             s;
    logic [IDX_W-1:0] cand;
    s = '0;
    // Walk from the farthest offset back to the nearest so the nearest hit wins.
    for (int i = NREQ - 1; i >= 0; i--) begin
      cand = start + IDX_W'(i);
      if (req[cand]) begin
        s.found = 1'b1;
        s.idx   = cand;
      end
    end
    return s;
  endfunction

endpackage

// File: rtl/grant_onehot_dec.sv
// Combinational index-to-one-hot decoder with an enable gate; produces the
// per-requester select lines from the registered grant index.
module grant_onehot_dec
  import arb_pkg::*;
(
  input  logic [IDX_W-1:0] idx,
  input  logic             en,
  output logic [NREQ-1:0]  onehot
);

  // Decode idx to a single set bit, or all-zero when disabled.
  always_comb begin
    // NOTE: assigning a default before any conditional write keeps this block
    // purely combinational; without it a path that skips the write infers a latch.
    onehot = '0;
    if (en) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/rr_arbiter8.sv
// Eight-requester round-robin arbiter with registered grant index and one-hot
// grant. A holder keeps the grant while its request stays high; on release
// the grant hands over directly to the next pending requester.
// Optional feature macro: ARB_TIMEOUT_EN enables hold-time preemption after
// HOLD_MAX consecutive grant cycles, signalled by a one-cycle tout pulse.
module rr_arbiter8
  import arb_pkg::*;
#(
  parameter int HOLD_MAX = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [NREQ-1:0]  req,
  output logic [NREQ-1:0]  gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             busy,
  output logic             tout
);

  // Reject hold limits outside the supported range at elaboration.
  if (HOLD_MAX < 2 || HOLD_MAX > 256) begin : g_bad_hold_max
    $error("rr_arbiter8: HOLD_MAX must be in 2..256");
  end

  state_t           state, state_n;
  logic [IDX_W-1:0] ptr, ptr_n;
  logic [IDX_W-1:0] idx_n;
  logic             busy_n;
  logic             rotate;
  sel_t             sel_idle;
  sel_t             sel_next;

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(HOLD_MAX + 1);
  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_MAX);

  logic [CNT_W-1:0] cnt, cnt_n;
  logic             tout_n;
  logic             expired;
`endif

  // State, pointer and grant registers; cleared asynchronously by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= '0;
      gnt_idx <= '0;
      busy    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every register here update from
      // the same pre-edge values, so the order of these lines does not matter.
      state   <= state_n;
      ptr     <= ptr_n;
      gnt_idx <= idx_n;
      busy    <= busy_n;
    end
  end

`ifdef ARB_TIMEOUT_EN
  // Hold counter and preemption pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      tout <= 1'b0;
    end else begin
      cnt  <= cnt_n;
      tout <= tout_n;
    end
  end
`else
  assign tout = 1'b0;
`endif

  // Next-state decision: new grant from IDLE, hold, release or preemption.
  always_comb begin
    state_n  = state;
    ptr_n    = ptr;
    idx_n    = gnt_idx;
    busy_n   = busy;
    rotate   = 1'b0;
    sel_idle = rr_search(req, ptr);
    sel_next = rr_search(req, gnt_idx + IDX_W'(1));
`ifdef ARB_TIMEOUT_EN
    cnt_n    = cnt;
    tout_n   = 1'b0;
    expired  = (cnt == HOLD_LIM);
`endif

    case (state)
      IDLE: begin
        if (en && sel_idle.found) begin
          idx_n   = sel_idle.idx;
          busy_n  = 1'b1;
          state_n = GRANT;
`ifdef ARB_TIMEOUT_EN
          cnt_n   = CNT_W'(1);
`endif
        end
      end

      GRANT: begin
        rotate = !req[gnt_idx];
`ifdef ARB_TIMEOUT_EN
        // A holder that is still requesting but has used its budget is preempted;
        // the search from gnt_idx+1 reaches the holder itself last.
        if (req[gnt_idx] && expired) begin
          rotate = 1'b1;
          tout_n = 1'b1;
        end
`endif
        if (rotate) begin
          ptr_n = gnt_idx + IDX_W'(1);
          if (en && sel_next.found) begin
            idx_n = sel_next.idx;
`ifdef ARB_TIMEOUT_EN
            cnt_n = CNT_W'(1);
`endif
          end else begin
            busy_n  = 1'b0;
            state_n = IDLE;
          end
        end else begin
`ifdef ARB_TIMEOUT_EN
          cnt_n = cnt + CNT_W'(1);
`endif
        end
      end

      default: begin
        state_n = IDLE;
        busy_n  = 1'b0;
      end
    endcase
  end

  grant_onehot_dec u_dec (
    .idx    (gnt_idx),
    .en     (busy),
    .onehot (gnt)
  );

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed self-checking bench for rr_arbiter8. Inputs change 1 time unit
// after a rising edge; outputs are sampled at that same point.
module tb_rr_arbiter8;
  import arb_pkg::*;

  logic             clk;
  logic             rst;
  logic             en;
  logic [NREQ-1:0]  req;
  logic [NREQ-1:0]  gnt;
  logic [IDX_W-1:0] gnt_idx;
  logic             busy;
  logic             tout;

  int errors;
  int checks;

  rr_arbiter8 #(.HOLD_MAX(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .req     (req),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .busy    (busy),
    .tout    (tout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    en  = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = '0;
    en  = 1'b0;
    #2;
    checks++;
    if ({gnt, gnt_idx, busy, tout} !== {8'h00, 3'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: gnt=%h idx=%0d busy=%b tout=%b, expected gnt=00 idx=0 busy=0 tout=0",
               gnt, gnt_idx, busy, tout);
    end
    step();
    rst = 1'b0;
    req = 8'h01;
    en  = 1'b1;
    step();
    checks++;
    if ({gnt, gnt_idx, busy} !== {8'h01, 3'd0, 1'b1}) begin
      errors++;
      $display("FAIL first_grant: gnt=%h idx=%0d busy=%b, expected gnt=01 idx=0 busy=1",
               gnt, gnt_idx, busy);
    end
    req = 8'h00;
    step();
    checks++;
    if ({gnt, busy} !== {8'h00, 1'b0}) begin
      errors++;
      $display("FAIL release_idle: gnt=%h busy=%b, expected gnt=00 busy=0", gnt, busy);
    end
  endtask

  task automatic test_rotation();
    logic [7:0] exp_gnt;
    do_reset();
    en  = 1'b1;
    req = 8'hFF;
    for (int i = 0; i < NREQ; i++) begin
      step();
      exp_gnt = 8'h01 << i;
      checks++;
      if ({gnt, gnt_idx, busy} !== {exp_gnt, 3'(i), 1'b1}) begin
        errors++;
        $display("FAIL rotation_%0d: gnt=%h idx=%0d busy=%b, expected gnt=%h idx=%0d busy=1",
                 i, gnt, gnt_idx, busy, exp_gnt, i);
      end
      req[i] = 1'b0;
    end
    step();
    checks++;
    if ({gnt, busy} !== {8'h00, 1'b0}) begin
      errors++;
      $display("FAIL rotation_end: gnt=%h busy=%b, expected gnt=00 busy=0", gnt, busy);
    end
  endtask

  task automatic test_wrap();
    // Pointer is 0 after the full rotation.
    req = 8'h20;
    step();
    checks++;
    if ({gnt, gnt_idx} !== {8'h20, 3'd5}) begin
      errors++;
      $display("FAIL wrap_grant5: gnt=%h idx=%0d, expected gnt=20 idx=5", gnt, gnt_idx);
    end
    req = 8'h00;
    step();
    req = 8'h21;
    step();
    checks++;
    if ({gnt, gnt_idx, busy} !== {8'h01, 3'd0, 1'b1}) begin
      errors++;
      $display("FAIL wrap_to_0: gnt=%h idx=%0d busy=%b, expected gnt=01 idx=0 busy=1",
               gnt, gnt_idx, busy);
    end
    req = 8'h20;
    step();
    checks++;
    if ({gnt, gnt_idx} !== {8'h20, 3'd5}) begin
      errors++;
      $display("FAIL wrap_then_5: gnt=%h idx=%0d, expected gnt=20 idx=5", gnt, gnt_idx);
    end
    req = 8'h00;
    step();
  endtask

  task automatic test_enable();
    // Pointer is 6 here.
    en  = 1'b0;
    req = 8'h10;
    step();
    step();
    checks++;
    if ({gnt, busy} !== {8'h00, 1'b0}) begin
      errors++;
      $display("FAIL en_blocks: gnt=%h busy=%b, expected gnt=00 busy=0", gnt, busy);
    end
    en = 1'b1;
    step();
    checks++;
    if ({gnt, gnt_idx, busy} !== {8'h10, 3'd4, 1'b1}) begin
      errors++;
      $display("FAIL en_grant: gnt=%h idx=%0d busy=%b, expected gnt=10 idx=4 busy=1",
               gnt, gnt_idx, busy);
    end
    en  = 1'b0;
    req = 8'h13;
    step();
    step();
    checks++;
    if ({gnt, busy} !== {8'h10, 1'b1}) begin
      errors++;
      $display("FAIL en_hold: gnt=%h busy=%b, expected gnt=10 busy=1", gnt, busy);
    end
    req = 8'h03;
    step();
    checks++;
    if ({gnt, busy} !== {8'h00, 1'b0}) begin
      errors++;
      $display("FAIL en_release: gnt=%h busy=%b, expected gnt=00 busy=0", gnt, busy);
    end
    step();
    checks++;
    if ({gnt, busy} !== {8'h00, 1'b0}) begin
      errors++;
      $display("FAIL en_pending_ignored: gnt=%h busy=%b, expected gnt=00 busy=0", gnt, busy);
    end
    req = 8'h00;
    en  = 1'b1;
  endtask

  task automatic test_timeout();
    logic [7:0] exp_gnt;
    logic       exp_tout;
    do_reset();
    en  = 1'b1;
    req = 8'h03;
`ifdef ARB_TIMEOUT_EN
    for (int k = 0; k < 16; k++) begin
      step();
      exp_gnt  = ((k / 4) % 2 == 1) ? 8'h02 : 8'h01;
      exp_tout = (k % 4 == 0) && (k > 0);
      checks++;
      if ({gnt, tout} !== {exp_gnt, exp_tout}) begin
        errors++;
        $display("FAIL timeout_alt_%0d: gnt=%h tout=%b, expected gnt=%h tout=%b",
                 k, gnt, tout, exp_gnt, exp_tout);
      end
    end
    req = 8'h01;
    for (int j = 0; j < 12; j++) begin
      step();
      exp_tout = (j % 4 == 0) && (j > 0);
      checks++;
      if ({gnt, busy, tout} !== {8'h01, 1'b1, exp_tout}) begin
        errors++;
        $display("FAIL timeout_solo_%0d: gnt=%h busy=%b tout=%b, expected gnt=01 busy=1 tout=%b",
                 j, gnt, busy, tout, exp_tout);
      end
    end
`else
    for (int k = 0; k < 10; k++) begin
      step();
      checks++;
      if ({gnt, busy, tout} !== {8'h01, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL no_timeout_%0d: gnt=%h busy=%b tout=%b, expected gnt=01 busy=1 tout=0",
                 k, gnt, busy, tout);
      end
    end
`endif
    req = 8'h00;
    step();
  endtask

  task automatic test_async_reset();
    do_reset();
    en  = 1'b1;
    req = 8'h04;
    step();
    checks++;
    if ({gnt, gnt_idx} !== {8'h04, 3'd2}) begin
      errors++;
      $display("FAIL pre_reset_grant: gnt=%h idx=%0d, expected gnt=04 idx=2", gnt, gnt_idx);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({gnt, gnt_idx, busy, tout} !== {8'h00, 3'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL async_reset: gnt=%h idx=%0d busy=%b tout=%b, expected all zero",
               gnt, gnt_idx, busy, tout);
    end
    req = 8'h80;
    step();
    rst = 1'b0;
    step();
    checks++;
    if ({gnt, gnt_idx, busy} !== {8'h80, 3'd7, 1'b1}) begin
      errors++;
      $display("FAIL post_reset_grant: gnt=%h idx=%0d busy=%b, expected gnt=80 idx=7 busy=1",
               gnt, gnt_idx, busy);
    end
    req = 8'h00;
    step();
  endtask

  task automatic test_glitch();
    // A request raised and dropped between two edges is never sampled.
    #2;
    req = 8'h04;
    #2;
    req = 8'h00;
    step();
    checks++;
    if ({gnt, busy} !== {8'h00, 1'b0}) begin
      errors++;
      $display("FAIL unsampled_req: gnt=%h busy=%b, expected gnt=00 busy=0", gnt, busy);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst    = 1'b1;
    en     = 1'b0;
    req    = '0;
    test_reset();
    test_rotation();
    test_wrap();
    test_enable();
    test_timeout();
    test_async_reset();
    test_glitch();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rr_arbiter8.md
# rr_arbiter8

- Round-robin arbiter sharing one resource among eight requesters.
- Grant is issued as a registered 3-bit index plus a one-hot 8-bit grant vector; the one-hot vector drives per-requester select lines downstream.
- A requester keeps the grant while it holds its request, with optional hold-time preemption.
- Sits between the requesters' req lines and the shared resource's select/enable inputs.

## Interface

Parameters:
- HOLD_MAX, 16: maximum consecutive grant cycles per requester. Legal range 2..256. Only used when ARB_TIMEOUT_EN is defined.

Ports:
- clk  input  1  rising-edge clock. One clock domain.
- rst  input  1  reset, asynchronous, active-high.
- en  input  1  arbitration enable; when low, no new grant is issued.
- req  input  8  request per requester; level-sensitive.
- gnt  output  8  one-hot grant, registered; all-zero when no grant.
- gnt_idx  output  3  index of the granted requester; valid only while busy=1.
- busy  output  1  high while any grant is active.
- tout  output  1  one-cycle pulse when a grant is preempted by the hold limit; constant 0 without ARB_TIMEOUT_EN.

## Operation

- State machine: IDLE, GRANT. Internal rotating pointer ptr[2:0] gives the highest-priority index.
- Selection:
  - Search starts at ptr and proceeds ptr, ptr+1, … modulo 8.
  - The first index with req=1 wins.
- IDLE:
  - If en=1 and |req: latch the winner into gnt_idx, set busy, and go to GRANT.
  - Otherwise stay in IDLE with gnt=0.
- GRANT while req[gnt_idx]=1: hold the grant; gnt and gnt_idx are stable.
- GRANT when req[gnt_idx]=0 (release):
  - ptr ← gnt_idx+1 (wraps 7→0).
  - If en=1 and another req is pending: grant the next winner directly (search from gnt_idx+1), staying in GRANT with no bubble cycle.
  - Otherwise go to IDLE with gnt=0 and busy=0.
- en deassertion: never revokes an active grant. It only blocks new grants at the next decision point.
- gnt is always exactly gnt_idx decoded to one-hot, gated by busy. gnt is never multi-hot.

## Timing

- Reset values: gnt=0, gnt_idx=0, busy=0, tout=0, ptr=0, state IDLE, hold counter 0.
- rst assertion clears all outputs immediately, with no clock needed. The first grant after reset goes to the lowest pending index.
- Grant latency: req sampled at clock edge N → gnt valid after edge N (visible in cycle N+1).
- Release latency: req[gnt_idx] falls before edge N → at edge N, gnt moves to the next winner or clears.
- Back-to-back handover produces no all-zero gnt cycle.
- A request asserted and dropped between edges without ever being sampled is never granted.

## Configuration

- ARB_TIMEOUT_EN defined:
  - A hold counter counts cycles with gnt active; it resets on every new grant.
  - After HOLD_MAX cycles of the same grant, the grant is preempted at the next edge: ptr ← gnt_idx+1, the winner is searched from gnt_idx+1, and tout pulses for one cycle.
  - If the current holder is the only requester, it is re-granted: gnt stays continuously high, the counter restarts, and tout still pulses.
  - If en=0 at preemption, go to IDLE.
- ARB_TIMEOUT_EN undefined: no counter; the grant lasts until the requester releases it; tout is tied 0.

## Structure

- Shared package arb_pkg:
  - NREQ=8, IDX_W=3.
  - State enum {IDLE, GRANT}.
  - Round-robin search function (req, start) → {found, idx}.
- Sub-module grant_onehot_dec: 3-bit index plus enable in, 8-bit one-hot out. Purely combinational. Instantiated once to produce gnt from the gnt_idx and busy registers.

## Test plan

1. Reset, then req=8'h01, en=1 → one cycle later gnt=8'h01, gnt_idx=0, busy=1. Drop req → next cycle gnt=0, busy=0.
2. req=8'hFF, each holder drops its bit one cycle after being granted → grant order 0,1,…,7, with no all-zero gnt cycles between handovers.
3. Grant index 5, then release with req=8'h21 (5 re-requests) → index 0 granted before index 5 (ptr=6 wraps through 7 to 0).
4. en=0 with req=8'h10 → gnt stays 0. en=1 during an active grant, then en=0, then release → grant held until release, then IDLE with pending requests ignored.
5. ARB_TIMEOUT_EN, HOLD_MAX=4, req=8'h03 constant → gnt=8'h01 for 4 cycles, then 8'h02 for 4 cycles, alternating, with a tout pulse at each switch. With req=8'h01 alone, gnt stays 8'h01 and tout pulses every 4 cycles.
6. rst asserted mid-grant between clock edges → gnt, busy and gnt_idx go to 0 immediately. After release with req=8'h80 → first grant is index 7, one cycle later.
